// File: rtl/lc3b_types.sv
// Shared types for the pmem scheduler slice: address/line types and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

  localparam int unsigned LC3B_WORD_W  = 16;
  localparam int unsigned LC3B_BLOCK_W = 128;

  typedef logic [LC3B_WORD_W-1:0]  lc3b_word;
  typedef logic [LC3B_BLOCK_W-1:0] lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } pmem_sched_state_t;

endpackage

// File: rtl/pmem_scheduler_if.sv
// Bundle of icache, dcache and pmem signals around the pmem scheduler.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the caches until their *_pmem_resp pulse.
// Modports: slave = scheduler side, master = environment (caches + memory).
interface pmem_scheduler_if
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W  = LC3B_WORD_W,
  parameter int unsigned BLOCK_W = LC3B_BLOCK_W
);
  logic               ic_pmem_read;
  logic [ADDR_W-1:0]  ic_pmem_address;
  logic               ic_pmem_resp;
  logic               dc_pmem_read;
  logic               dc_pmem_write;
  logic [ADDR_W-1:0]  dc_pmem_address;
  logic [BLOCK_W-1:0] dc_pmem_wdata;
  logic               dc_pmem_resp;
  logic               pmem_resp;
  logic               pmem_read;
  logic               pmem_write;
  logic [ADDR_W-1:0]  pmem_address;
  logic [BLOCK_W-1:0] pmem_wdata;
  logic               pipe_advance;

  modport slave (
    input  ic_pmem_read, ic_pmem_address,
    input  dc_pmem_read, dc_pmem_write, dc_pmem_address, dc_pmem_wdata,
    input  pmem_resp,
    output ic_pmem_resp, dc_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pipe_advance
  );

  modport master (
    output ic_pmem_read, ic_pmem_address,
    output dc_pmem_read, dc_pmem_write, dc_pmem_address, dc_pmem_wdata,
    output pmem_resp,
    input  ic_pmem_resp, dc_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pipe_advance
  );

endinterface

// File: rtl/pmem_sched_prio.sv
// Winner select between icache and dcache with an icache starvation counter.
// Latency: grant outputs are combinational; the counter updates on decide edges.
// Backpressure: none; the FSM only acts on grants while decide is high.
// Ports: clk/rst_n, ic_req/dc_req (pending requests), decide (FSM in IDLE),
//        grant_i/grant_d (one-hot-or-zero winner).
module pmem_sched_prio
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ic_req,
  input  logic dc_req,
  input  logic decide,
  output logic grant_i,
  output logic grant_d
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved;

  assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    // dcache wins contested decisions unless icache has waited STARVE_MAX times
    grant_i      = ic_req && (!dc_req || starved);
    grant_d      = dc_req && !grant_i;
    starve_cnt_d = starve_cnt_q;
    if (decide) begin
      if (grant_i) begin
        starve_cnt_d = '0;
      end else if (grant_d) begin
        if (!ic_req)       starve_cnt_d = '0;
        else if (!starved) starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/pmem_scheduler.sv
// Arbitrates the single pmem port between icache fills and dcache fills/write-backs.
// Latency: request seen in IDLE at edge N drives pmem from cycle N+1; RECOVER then IDLE follow each resp.
// Backpressure: caches hold requests until their resp pulse; pipe_advance stalls the pipeline meanwhile.
// Ports: clk, rst_n, bus (slave modport: cache requests/resps, pmem command/resp, pipe_advance).
module pmem_scheduler
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W     = LC3B_WORD_W,
  parameter int unsigned BLOCK_W    = LC3B_BLOCK_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  pmem_scheduler_if.slave  bus
);

  pmem_sched_state_t  state_q, state_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;

  logic ic_req, dc_req, in_idle, in_grant, grant_i, grant_d;

  assign ic_req   = bus.ic_pmem_read;
  assign dc_req   = bus.dc_pmem_read | bus.dc_pmem_write;
  assign in_idle  = (state_q == IDLE);
  assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

  pmem_sched_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .ic_req  (ic_req),
    .dc_req  (dc_req),
    .decide  (in_idle),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d = GRANT_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = bus.ic_pmem_address;
          wdata_d = '0;
        end else if (grant_d) begin
          // read+write together is illegal; the write-back wins
          state_d = GRANT_D;
          wr_d    = bus.dc_pmem_write;
          rd_d    = bus.dc_pmem_read & ~bus.dc_pmem_write;
          addr_d  = bus.dc_pmem_address;
          wdata_d = bus.dc_pmem_wdata;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.pmem_resp) begin
          state_d = RECOVER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // pmem is driven only from the holding registers so it ignores input churn
  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.ic_pmem_resp = (state_q == GRANT_I) & bus.pmem_resp;
  assign bus.dc_pmem_resp = (state_q == GRANT_D) & bus.pmem_resp;
  assign bus.pipe_advance = (in_idle & ~ic_req & ~dc_req) | (in_grant & bus.pmem_resp);

endmodule

// File: tb/tb_pmem_scheduler.sv
// Self-checking bench for pmem_scheduler: directed scenarios then randomized rounds.
// Latency: n/a (testbench).
// Backpressure: the bench plays both caches and the memory, holding requests until resp.
module tb_pmem_scheduler;
  import lc3b_types::*;

  localparam int ADDR_W     = 16;
  localparam int BLOCK_W    = 128;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_scheduler_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  pmem_scheduler #(
    .ADDR_W     (ADDR_W),
    .BLOCK_W    (BLOCK_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: record of past arbitration decisions. Icache wins a contested
  // decision exactly when the last STARVE_MAX decisions were all dcache wins
  // taken while icache was waiting.
  typedef struct packed {
    bit won_i;
    bit ic_waiting;
  } dec_t;
  dec_t hist[$];

  function automatic bit model_pick(input bit ic, input bit dc);
    bit starved;
    bit pick_i;
    dec_t e;
    starved = (hist.size() >= STARVE_MAX);
    for (int k = 0; k < STARVE_MAX; k++) begin
      if (starved) begin
        e = hist[hist.size() - 1 - k];
        if (e.won_i || !e.ic_waiting) starved = 1'b0;
      end
    end
    pick_i = ic && (!dc || starved);
    e.won_i      = pick_i;
    e.ic_waiting = ic;
    hist.push_back(e);
    if (hist.size() > 16) void'(hist.pop_front());
    return pick_i;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the scheduler in IDLE and requests applied.
  // Leaves at the negedge of the following IDLE cycle.
  task automatic run_txn(input string tag, input bit exp_i, input bit exp_wr,
                         input logic [ADDR_W-1:0] exp_addr, input logic [BLOCK_W-1:0] exp_wdata,
                         input int lat, input bit perturb, input bit drop, input bit release_req);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1 && perturb) begin
        if (exp_i) bus.ic_pmem_address = bus.ic_pmem_address ^ 16'h1000;
        else begin
          bus.dc_pmem_address = bus.dc_pmem_address ^ 16'h1000;
          bus.dc_pmem_wdata   = ~bus.dc_pmem_wdata;
        end
      end
      if (c == 1 && drop) begin
        if (exp_i) bus.ic_pmem_read = 1'b0;
        else begin
          bus.dc_pmem_read  = 1'b0;
          bus.dc_pmem_write = 1'b0;
        end
      end
      #1;
      chk1({tag, "/hold_rd"}, bus.pmem_read, !exp_wr);
      chk1({tag, "/hold_wr"}, bus.pmem_write, exp_wr);
      chkv({tag, "/hold_addr"}, BLOCK_W'(bus.pmem_address), BLOCK_W'(exp_addr));
      if (exp_wr) chkv({tag, "/hold_wdata"}, bus.pmem_wdata, exp_wdata);
      chk1({tag, "/hold_pipe"}, bus.pipe_advance, 1'b0);
      chk1({tag, "/hold_ic_resp"}, bus.ic_pmem_resp, 1'b0);
      chk1({tag, "/hold_dc_resp"}, bus.dc_pmem_resp, 1'b0);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk1({tag, "/resp_rd"}, bus.pmem_read, !exp_wr);
    chk1({tag, "/resp_wr"}, bus.pmem_write, exp_wr);
    chk1({tag, "/ic_resp"}, bus.ic_pmem_resp, exp_i);
    chk1({tag, "/dc_resp"}, bus.dc_pmem_resp, !exp_i);
    chk1({tag, "/resp_pipe"}, bus.pipe_advance, 1'b1);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    if (release_req) begin
      if (exp_i) bus.ic_pmem_read = 1'b0;
      else begin
        bus.dc_pmem_read  = 1'b0;
        bus.dc_pmem_write = 1'b0;
      end
    end
    #1;
    chk1({tag, "/rec_rd"}, bus.pmem_read, 1'b0);
    chk1({tag, "/rec_wr"}, bus.pmem_write, 1'b0);
    chk1({tag, "/rec_ic_resp"}, bus.ic_pmem_resp, 1'b0);
    chk1({tag, "/rec_dc_resp"}, bus.dc_pmem_resp, 1'b0);
    chk1({tag, "/rec_pipe"}, bus.pipe_advance, 1'b0);
    @(negedge clk);
    #1;
    chk1({tag, "/idle_pipe"}, bus.pipe_advance,
         !(bus.ic_pmem_read | bus.dc_pmem_read | bus.dc_pmem_write));
  endtask

  initial begin
    logic [ADDR_W-1:0]  a_ic, a_dc, e_addr;
    logic [BLOCK_W-1:0] wd;
    bit pick, ic_on, dc_on, e_wr;

    bus.ic_pmem_read    = 1'b0;
    bus.ic_pmem_address = '0;
    bus.dc_pmem_read    = 1'b0;
    bus.dc_pmem_write   = 1'b0;
    bus.dc_pmem_address = '0;
    bus.dc_pmem_wdata   = '0;
    bus.pmem_resp       = 1'b0;

    // Reset state
    #12;
    chk1("rst/rd", bus.pmem_read, 1'b0);
    chk1("rst/wr", bus.pmem_write, 1'b0);
    chkv("rst/addr", BLOCK_W'(bus.pmem_address), '0);
    chkv("rst/wdata", bus.pmem_wdata, '0);
    chk1("rst/ic_resp", bus.ic_pmem_resp, 1'b0);
    chk1("rst/dc_resp", bus.dc_pmem_resp, 1'b0);
    chk1("rst/pipe", bus.pipe_advance, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // icache read only
    bus.ic_pmem_read    = 1'b1;
    bus.ic_pmem_address = 16'h1230;
    pick = model_pick(1'b1, 1'b0);
    run_txn("ic_only", pick, 1'b0, 16'h1230, '0, 4, 1'b0, 1'b0, 1'b1);

    // dcache write-back with inputs changed mid-grant
    wd = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    bus.dc_pmem_write   = 1'b1;
    bus.dc_pmem_address = 16'h4000;
    bus.dc_pmem_wdata   = wd;
    pick = model_pick(1'b0, 1'b1);
    run_txn("dc_wb", pick, 1'b1, 16'h4000, wd, 3, 1'b1, 1'b0, 1'b1);

    // Both requesting continuously: starvation guard
    bus.ic_pmem_read    = 1'b1;
    bus.ic_pmem_address = 16'h0110;
    bus.dc_pmem_read    = 1'b1;
    bus.dc_pmem_address = 16'h0220;
    for (int g = 0; g < 10; g++) begin
      pick = model_pick(1'b1, 1'b1);
      run_txn(pick ? "contend_i" : "contend_d", pick, 1'b0, pick ? 16'h0110 : 16'h0220, '0,
              $urandom_range(1, 3), 1'b0, 1'b0, 1'b0);
    end
    bus.ic_pmem_read = 1'b0;
    bus.dc_pmem_read = 1'b0;
    @(negedge clk);

    // Illegal read+write: write wins
    wd = {$urandom, $urandom, $urandom, $urandom};
    bus.dc_pmem_read    = 1'b1;
    bus.dc_pmem_write   = 1'b1;
    bus.dc_pmem_address = 16'h2222;
    bus.dc_pmem_wdata   = wd;
    pick = model_pick(1'b0, 1'b1);
    run_txn("dc_rw", pick, 1'b1, 16'h2222, wd, 2, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset two cycles into a dcache grant
    bus.dc_pmem_read    = 1'b1;
    bus.dc_pmem_address = 16'h3330;
    void'(model_pick(1'b0, 1'b1));
    @(negedge clk); #1;
    chk1("arst/rd_c1", bus.pmem_read, 1'b1);
    @(negedge clk); #1;
    chk1("arst/rd_c2", bus.pmem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst/rd_drop", bus.pmem_read, 1'b0);
    chkv("arst/addr", BLOCK_W'(bus.pmem_address), '0);
    chk1("arst/pipe", bus.pipe_advance, 1'b0);
    hist.delete();
    @(negedge clk);
    bus.dc_pmem_read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk1("stray/ic_resp", bus.ic_pmem_resp, 1'b0);
    chk1("stray/dc_resp", bus.dc_pmem_resp, 1'b0);
    chk1("stray/rd", bus.pmem_read, 1'b0);
    chk1("stray/pipe", bus.pipe_advance, 1'b1);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    @(negedge clk);

    // icache request dropped mid-grant
    bus.ic_pmem_read    = 1'b1;
    bus.ic_pmem_address = 16'h0ABC;
    pick = model_pick(1'b1, 1'b0);
    run_txn("ic_drop", pick, 1'b0, 16'h0ABC, '0, 3, 1'b0, 1'b1, 1'b1);

    // Randomized rounds against the reference
    ic_on = 1'b0;
    dc_on = 1'b0;
    for (int r = 0; r < 60; r++) begin
      if (!ic_on && ($urandom % 2 == 0)) begin
        ic_on = 1'b1;
        bus.ic_pmem_read    = 1'b1;
        bus.ic_pmem_address = ADDR_W'($urandom);
      end
      if (!dc_on && ($urandom % 2 == 0)) begin
        dc_on = 1'b1;
        bus.dc_pmem_write   = ($urandom % 2 == 0);
        bus.dc_pmem_read    = !bus.dc_pmem_write;
        bus.dc_pmem_address = ADDR_W'($urandom);
        bus.dc_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!ic_on && !dc_on) begin
        #1;
        chk1("rnd/idle_pipe", bus.pipe_advance, 1'b1);
        chk1("rnd/idle_rd", bus.pmem_read, 1'b0);
        @(negedge clk);
      end else begin
        a_ic = bus.ic_pmem_address;
        a_dc = bus.dc_pmem_address;
        wd   = bus.dc_pmem_wdata;
        pick = model_pick(ic_on, dc_on);
        e_addr = pick ? a_ic : a_dc;
        e_wr   = !pick && bus.dc_pmem_write;
        run_txn(pick ? "rnd_i" : "rnd_d", pick, e_wr, e_addr, wd,
                $urandom_range(1, 5), ($urandom % 2 == 0), 1'b0, 1'b1);
        if (pick) ic_on = 1'b0;
        else      dc_on = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
